// File: rtl/gray_frame_writer.sv
// Write-back stage for the grayscale pipeline: buffers processed pixels in a small FIFO
// and issues addressed SDRAM write requests under backpressure, one frame per start.
module gray_frame_writer #(
  parameter int unsigned NUM_PIXEL  = 307200,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_valid,
  input  logic [9:0]        i_color,
  input  logic              i_bw,
  input  logic              i_wr_full,
  output logic              o_write_request,
  output logic [15:0]       o_wr_data,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IC_W  = ADDR_W + 1;
  localparam int unsigned ENT_W = 11 + ADDR_W;
  localparam logic [IC_W-1:0]  NUM_PIXEL_C = IC_W'(NUM_PIXEL);
  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [IC_W-1:0]    in_count_q, in_count_d;
  logic               overflow_q, overflow_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic               wr_req_q, wr_req_d;
  logic [15:0]        wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]   entry_d, head;
  logic               fifo_empty, fifo_full, accept, push, pop;

  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == DEPTH_C);
  assign head       = mem_q[rd_ptr_q];
  assign entry_d    = {i_bw, i_color, in_count_q[ADDR_W-1:0]};

  // Frame sequencing, FIFO push/pop decisions and output register next-values.
  always_comb begin
    state_d    = state_q;
    in_count_d = in_count_q;
    overflow_d = overflow_q;
    accept     = 1'b0;
    pop        = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !fifo_empty && !i_wr_full;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          in_count_d = '0;
          overflow_d = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (in_count_q == NUM_PIXEL_C) state_d = S_DRAIN;
        else                           accept  = i_valid;
      end
      S_DRAIN: begin
        if (fifo_empty) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A full FIFO still takes the pixel when the head leaves in the same cycle.
    push = accept && (!fifo_full || pop);
    if (accept) in_count_d = in_count_q + IC_W'(1);
    if (accept && !push) overflow_d = 1'b1;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + CNT_W'(1);
      2'b01:   fcnt_d = fcnt_q - CNT_W'(1);
      default: fcnt_d = fcnt_q;
    endcase

    wr_req_d  = pop;
    wr_data_d = pop ? {5'b0, head[ENT_W-1 -: 11]} : wr_data_q;
    wr_addr_d = pop ? head[ADDR_W-1:0] : wr_addr_q;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      in_count_q <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      wr_req_q   <= 1'b0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_count_q <= in_count_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      wr_req_q   <= wr_req_d;
      wr_data_q  <= wr_data_d;
      wr_addr_q  <= wr_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Storage needs no reset: entries are only read behind a non-zero count.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_d;
  end

  assign o_write_request = wr_req_q;
  assign o_wr_data       = wr_data_q;
  assign o_wr_addr       = wr_addr_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_overflow      = overflow_q;

endmodule

// File: tb/tb_gray_frame_writer.sv
// Scoreboard bench for gray_frame_writer: stimulus queues expected writes, a monitor
// pops and compares on every write strobe and checks done/busy timing.
module tb_gray_frame_writer;

  localparam int unsigned NP = 16;
  localparam int unsigned AW = 20;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_start;
  logic          i_valid;
  logic [9:0]    i_color;
  logic          i_bw;
  logic          i_wr_full;
  logic          o_write_request;
  logic [15:0]   o_wr_data;
  logic [AW-1:0] o_wr_addr;
  logic          o_busy;
  logic          o_done;
  logic          o_overflow;

  gray_frame_writer #(.NUM_PIXEL(NP), .FIFO_DEPTH(8), .ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_valid(i_valid),
    .i_color(i_color), .i_bw(i_bw), .i_wr_full(i_wr_full),
    .o_write_request(o_write_request), .o_wr_data(o_wr_data), .o_wr_addr(o_wr_addr),
    .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  wr_cnt = 0;
  int  done_cnt = 0;
  int  first_wr_cyc = -1;
  bit  first_pending = 0;
  bit  prev_wr = 0;
  bit  prev_done = 0;
  int  v0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every write strobe against the scoreboard head.
  always @(negedge i_clk) begin
    wr_t e;
    if (i_rst_n) begin
      if (o_write_request) begin
        wr_cnt++;
        if (first_pending) begin
          first_wr_cyc  = cyc;
          first_pending = 0;
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual_addr=%0h required=none (cycle %0d)", o_wr_addr, cyc);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(o_wr_addr), 64'(e.addr));
          check("wr_data", 64'(o_wr_data), 64'(e.data));
        end
      end
      if (o_done) begin
        done_cnt++;
        check("done_after_last_write", 64'(prev_wr), 64'(1));
        check("queue_empty_at_done", 64'(exp_q.size()), 64'(0));
      end
      if (prev_done) begin
        check("done_single_cycle", 64'(o_done), 64'(0));
        check("busy_low_after_done", 64'(o_busy), 64'(0));
      end
      prev_wr   = o_write_request;
      prev_done = o_done;
    end else begin
      prev_wr   = 0;
      prev_done = 0;
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_frame();
    i_valid = 1'b0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("busy_after_start", 64'(o_busy), 64'(1));
  endtask

  task automatic send(input int idx, input logic full, input bit expect_acc);
    wr_t e;
    i_valid   = 1'b1;
    i_color   = 10'(idx);
    i_bw      = idx[0];
    i_wr_full = full;
    if (expect_acc) begin
      e.addr = AW'(idx);
      e.data = {5'b0, idx[0], 10'(idx)};
      exp_q.push_back(e);
    end
    step();
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    i_valid = 1'b0;
    while (done_cnt < target && n < 300) begin
      step();
      n++;
    end
    step();
    check("done_count", 64'(done_cnt), 64'(target));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_write_request"}, 64'(o_write_request), 64'(0));
    check({tag, "_wr_data"},       64'(o_wr_data),       64'(0));
    check({tag, "_wr_addr"},       64'(o_wr_addr),       64'(0));
    check({tag, "_busy"},          64'(o_busy),          64'(0));
    check({tag, "_done"},          64'(o_done),          64'(0));
    check({tag, "_overflow"},      64'(o_overflow),      64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_valid = 1'b0;
    i_color = '0; i_bw = 1'b0; i_wr_full = 1'b0;
    step(); step();
    check_outputs_zero("reset");
    i_rst_n = 1'b1;
    step();

    // Basic frame, no backpressure
    start_frame();
    wr_cnt = 0;
    first_pending = 1;
    for (int i = 0; i < NP; i++) begin
      send(i, 1'b0, 1'b1);
      if (i == 0) v0 = cyc;
    end
    wait_done(1);
    check("first_write_latency", 64'(first_wr_cyc), 64'(v0 + 1));
    check("basic_overflow", 64'(o_overflow), 64'(0));
    check("basic_write_count", 64'(wr_cnt), 64'(NP));

    // Backpressure for 6 cycles mid-frame, no loss
    start_frame();
    wr_cnt = 0;
    for (int i = 0; i < NP; i++) send(i, (i >= 5 && i < 11), 1'b1);
    wait_done(2);
    check("bp_overflow", 64'(o_overflow), 64'(0));
    check("bp_write_count", 64'(wr_cnt), 64'(NP));

    // Overflow: write port blocked 12 cycles from first valid, pixels 8..11 dropped
    start_frame();
    wr_cnt = 0;
    for (int i = 0; i < NP; i++) begin
      send(i, (i < 12), !(i >= 8 && i < 12));
      if (i == 7) check("ovf_before_drop", 64'(o_overflow), 64'(0));
      if (i == 8) check("ovf_on_first_drop", 64'(o_overflow), 64'(1));
    end
    wait_done(3);
    check("ovf_sticky_after_done", 64'(o_overflow), 64'(1));
    check("ovf_write_count", 64'(wr_cnt), 64'(12));

    // Ignored inputs: valids in IDLE, start mid-frame, valids in DRAIN
    wr_cnt = 0;
    for (int i = 0; i < 3; i++) send(i + 40, 1'b0, 1'b0);
    check("idle_valids_ignored_busy", 64'(o_busy), 64'(0));
    start_frame();
    check("ovf_cleared_by_start", 64'(o_overflow), 64'(0));
    for (int i = 0; i < NP; i++) begin
      i_start = (i == 6);
      send(i, (i >= 12), 1'b1);
    end
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) send(i + 16, 1'b1, 1'b0);
    i_wr_full = 1'b0;
    wait_done(4);
    check("ignored_write_count", 64'(wr_cnt), 64'(NP));
    check("ignored_overflow", 64'(o_overflow), 64'(0));

    // Reset mid-frame with 3 pixels still buffered
    start_frame();
    wr_cnt = 0;
    send(0, 1'b0, 1'b1);
    send(1, 1'b0, 1'b1);
    send(2, 1'b0, 1'b0);
    send(3, 1'b1, 1'b0);
    send(4, 1'b1, 1'b0);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    step(); step();
    i_wr_full = 1'b0;
    i_rst_n   = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("no_writes_after_reset", 64'(wr_cnt), 64'(2));
    check("idle_after_reset", 64'(o_busy), 64'(0));
    start_frame();
    wr_cnt = 0;
    for (int i = 0; i < NP; i++) send(i, 1'b0, 1'b1);
    wait_done(5);
    check("post_reset_write_count", 64'(wr_cnt), 64'(NP));
    check("post_reset_last_addr", 64'(o_wr_addr), 64'(NP - 1));

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_frame_writer.md
# gray_frame_writer

Write-back end of the grayscale pipeline: accepts the processed pixel stream (gray level plus black/white bit) that the grayscale stage emits one pixel per cycle after reading a frame from SDRAM, buffers it in a small FIFO, and issues addressed write requests to the SDRAM write port under backpressure. One frame of `NUM_PIXEL` pixels per `i_start`. Signals completion with a one-cycle `o_done`, and flags dropped pixels with a sticky overflow bit.

## Interface
- `NUM_PIXEL`, 307200: pixels per frame (640×480).
- `FIFO_DEPTH`, 8: FIFO entries; power of two, ≥2.
- `ADDR_W`, 20: pixel index width; must hold `NUM_PIXEL-1`.

Ports:
- `i_clk`  in  1  single clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  frame start; sampled only in IDLE.
- `i_valid`  in  1  upstream pixel valid; there is no ready signal back to upstream.
- `i_color`  in  10  gray level.
- `i_bw`  in  1  black/white bit (1 = dark).
- `i_wr_full`  in  1  SDRAM write port cannot accept this cycle.
- `o_write_request`  out  1  one-cycle write strobe.
- `o_wr_data`  out  16  `{5'b0, bw, color[9:0]}`.
- `o_wr_addr`  out  `ADDR_W`  pixel index of `o_wr_data`.
- `o_busy`  out  1  state ≠ IDLE.
- `o_done`  out  1  one-cycle pulse at frame completion.
- `o_overflow`  out  1  sticky; set when a pixel is dropped.

## Operation
- **States.**
  - IDLE: if `i_start`, clear `in_count` and `o_overflow`, then go to RUN.
  - RUN: accept pixels. When `in_count` reaches `NUM_PIXEL`, go to DRAIN.
  - DRAIN: when the FIFO is empty, go to DONE.
  - DONE: pulse `o_done`, then go to IDLE.
- **Accept (RUN only).**
  - On `i_valid`, push `{i_bw, i_color, in_count}` and increment `in_count`.
  - `i_valid` is ignored in IDLE, DRAIN and DONE, and in RUN once `in_count == NUM_PIXEL`.
- **Full FIFO.**
  - If the FIFO is full and no pop occurs in the same cycle, the pixel is dropped.
  - On a drop, `in_count` still increments and `o_overflow` is set.
  - The stored index keeps addresses exact; dropped pixels leave holes in the SDRAM image.
- **Pop.**
  - Every cycle, if the FIFO is non-empty and `!i_wr_full`, pop the head into the output registers and assert `o_write_request` for the next cycle.
  - Otherwise `o_write_request` is 0 next cycle and `o_wr_data`/`o_wr_addr` hold their values.
  - Pops occur in RUN and in DRAIN.
- **Simultaneous events.**
  - Push and pop in the same cycle on a full FIFO: no drop; the count is unchanged.
  - Push and pop in the same cycle on an empty FIFO: the pixel is pushed; that cycle's pop sees the FIFO as empty, so the pixel leaves on a later cycle. There is no bypass.
- **Mid-frame `i_start`:** ignored.
- **Reset (any time, including mid-frame):**
  - All outputs go to 0 and the state goes to IDLE.
  - The FIFO is emptied and `in_count` is set to 0.
  - Pending pixels are discarded.

## Timing
- **Reset values:** `o_write_request`, `o_wr_data`, `o_wr_addr`, `o_busy`, `o_done` and `o_overflow` are all 0.
- **Start:** `i_start` sampled at edge E makes `o_busy` 1 after E. The first pixel can be accepted at edge E+1.
- **Latency:** a pixel sampled at edge N, with the FIFO empty and `i_wr_full` low, gives `o_write_request` = 1 in the cycle after edge N+1 (2 cycles).
- **Throughput:** with `i_wr_full` low, 1 write per cycle is sustained and nothing is dropped.
- **Backpressure:** `i_wr_full` is evaluated in the same cycle as the pop decision. A write strobe already issued is never retracted.
- **Done:** `o_done` is high for exactly 1 cycle, in the cycle after the last `o_write_request`. `o_busy` falls to 0 the cycle after `o_done`.
- **Counter width:** `in_count` is `ADDR_W+1` bits, so that `NUM_PIXEL` itself is representable.

## Test plan
- **Basic frame:**
  - Stimulus: `NUM_PIXEL`=16; `i_start`, then 16 consecutive valids with color = index, bw = index[0], `i_wr_full` held 0.
  - Required: 16 writes, with addr 0..15 and data = `{5'b0, i[0], i}`. First write 2 cycles after the first valid. `o_done` 1 cycle after the last write. `o_overflow` = 0.
- **Backpressure without loss:**
  - Stimulus: `NUM_PIXEL`=16; `i_wr_full` high for 6 cycles mid-frame.
  - Required: all 16 addresses written in order, no drop, `o_overflow` = 0.
- **Overflow:**
  - Stimulus: `NUM_PIXEL`=16, `FIFO_DEPTH`=8; `i_wr_full` high for 12 cycles from the first valid.
  - Required: 4 pixels dropped. Exactly the addresses of the accepted pixels are written (holes are absent from the write sequence). `o_overflow` = 1 after the first drop and stays 1 after `o_done`. The next `i_start` clears it.
- **Ignored inputs:**
  - Stimulus: valids before `i_start`; `i_start` mid-frame; valids in DRAIN.
  - Required: no extra writes; the frame completes normally.
- **Reset mid-frame:**
  - Stimulus: assert `i_rst_n` low after 5 of 16 pixels, with 3 pixels still in the FIFO.
  - Required: all outputs 0 immediately. No further writes. A fresh `i_start` runs a clean frame starting at addr 0.
- **Full-size frame:**
  - Stimulus: `NUM_PIXEL`=307200, continuous valids.
  - Required: last write has addr 307199; exactly 1 `o_done` pulse.
